// File: rtl/matriz_loader_if.sv
// Byte-wide synchronous memory read port between the matrix loader and its
// backing memory.
interface matriz_loader_if #(
  parameter int ADDR_W = 9
) ();
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;

  modport master (output mem_rd, output mem_addr, input mem_rdata);
  modport slave  (input mem_rd, input mem_addr, output mem_rdata);
endinterface

// File: rtl/matriz_loader.sv
// Streams an NxN byte matrix from memory into the zero-padded 5x5 row-major
// vector used by the multiplier; one read request per cycle.
module matriz_loader #(
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [2:0]          tamanho,
  matriz_loader_if.master     mem,
  output logic [199:0]        matriz,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        row_q, row_d;
  logic [2:0]        col_q, col_d;
  logic [4:0]        idx_q, idx_d;
  logic [4:0]        row_base_q, row_base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [199:0]      matriz_q, matriz_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [4:0]        dst_q [RD_LAT];
  logic [4:0]        dst_d [RD_LAT];

  logic       issue;
  logic       last_req;
  logic       col_wrap;
  logic [2:0] n_sel;
  logic [7:0] wr_bit;

  always_comb begin
    n_sel    = (tamanho == 3'd0 || tamanho > 3'd5) ? 3'd5 : tamanho;
    issue    = (state_q == S_ISSUE);
    col_wrap = (col_q == n_q - 3'd1);
    last_req = col_wrap && (row_q == n_q - 3'd1);
    wr_bit   = {dst_q[RD_LAT-1], 3'b000};

    state_d    = state_q;
    n_d        = n_q;
    row_d      = row_q;
    col_d      = col_q;
    idx_d      = idx_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    matriz_d   = matriz_q;

    // Read pipeline: valid bit and destination slot travel with each request
    vld_d[0] = issue;
    dst_d[0] = idx_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      dst_d[i] = dst_q[i-1];
    end

    if (vld_q[RD_LAT-1]) begin
      matriz_d[wr_bit +: 8] = mem.mem_rdata;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ISSUE;
          n_d        = n_sel;
          addr_d     = base_addr;
          row_d      = 3'd0;
          col_d      = 3'd0;
          idx_d      = 5'd0;
          row_base_d = 5'd0;
          matriz_d   = '0;
        end
      end
      S_ISSUE: begin
        // Row-major walk of memory is a plain increment; only the packed
        // destination index jumps by the fixed stride of 5 at row ends.
        addr_d = addr_q + 1'b1;
        if (col_wrap) begin
          col_d      = 3'd0;
          row_d      = row_q + 3'd1;
          row_base_d = row_base_q + 5'd5;
          idx_d      = row_base_q + 5'd5;
        end else begin
          col_d = col_q + 3'd1;
          idx_d = idx_q + 5'd1;
        end
        if (last_req) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (vld_d == '0) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      n_q        <= 3'd0;
      row_q      <= 3'd0;
      col_q      <= 3'd0;
      idx_q      <= 5'd0;
      row_base_q <= 5'd0;
      addr_q     <= '0;
      matriz_q   <= '0;
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      row_q      <= row_d;
      col_q      <= col_d;
      idx_q      <= idx_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      matriz_q   <= matriz_d;
      vld_q      <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < RD_LAT; i++) begin
      dst_q[i] <= dst_d[i];
    end
  end

  assign mem.mem_rd   = issue;
  assign mem.mem_addr = addr_q;
  assign matriz       = matriz_q;
  assign busy         = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_matriz_loader.sv
// Bench for matriz_loader: two instances (read latency 1 and 3) against
// behavioural memories, with an address scoreboard and per-scenario checks.
module tb_matriz_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic         rst_a, start_a, busy_a, done_a;
  logic [8:0]   base_a;
  logic [2:0]   tam_a;
  logic [199:0] mat_a;
  logic         rst_b, start_b, busy_b, done_b;
  logic [8:0]   base_b;
  logic [2:0]   tam_b;
  logic [199:0] mat_b;

  matriz_loader_if #(.ADDR_W(9)) mem_a ();
  matriz_loader_if #(.ADDR_W(9)) mem_b ();

  matriz_loader #(.ADDR_W(9), .RD_LAT(1)) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .base_addr(base_a),
    .tamanho(tam_a), .mem(mem_a), .matriz(mat_a), .busy(busy_a), .done(done_a));

  matriz_loader #(.ADDR_W(9), .RD_LAT(3)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .base_addr(base_b),
    .tamanho(tam_b), .mem(mem_b), .matriz(mat_b), .busy(busy_b), .done(done_b));

  logic [7:0] marr_a [512];
  logic [7:0] marr_b [512];
  logic [7:0] pa;
  logic [7:0] pb [3];

  always @(posedge clk) pa <= mem_a.mem_rd ? marr_a[mem_a.mem_addr] : 8'hEE;
  assign mem_a.mem_rdata = pa;

  always @(posedge clk) begin
    pb[0] <= mem_b.mem_rd ? marr_b[mem_b.mem_addr] : 8'hEE;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign mem_b.mem_rdata = pb[2];

  logic [8:0] qa [$];
  logic [8:0] qb [$];
  logic [8:0] ea, eb;

  always @(negedge clk) begin
    if (mem_a.mem_rd === 1'b1) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL rd_addr_a: unexpected read at %h, no read required", mem_a.mem_addr);
      end else begin
        ea = qa.pop_front();
        if (mem_a.mem_addr !== ea) begin
          errors++;
          $display("FAIL rd_addr_a: got %h, want %h", mem_a.mem_addr, ea);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mem_b.mem_rd === 1'b1) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL rd_addr_b: unexpected read at %h, no read required", mem_b.mem_addr);
      end else begin
        eb = qb.pop_front();
        if (mem_b.mem_addr !== eb) begin
          errors++;
          $display("FAIL rd_addr_b: got %h, want %h", mem_b.mem_addr, eb);
        end
      end
    end
  end

  function automatic logic [199:0] exp_mat(input bit use_b, input logic [8:0] base, input int n);
    logic [199:0] m;
    logic [8:0]   a;
    m = '0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        a = base + 9'(r * n + c);
        m[8*(c + 5*r) +: 8] = use_b ? marr_b[a] : marr_a[a];
      end
    return m;
  endfunction

  task automatic push_a(input logic [8:0] base, input int n);
    for (int k = 0; k < n * n; k++) qa.push_back(base + 9'(k));
  endtask

  task automatic push_b(input logic [8:0] base, input int n);
    for (int k = 0; k < n * n; k++) qb.push_back(base + 9'(k));
  endtask

  // Leaves the caller in cycle 1 of the new load (one cycle after acceptance).
  task automatic start_load_a(input logic [8:0] base, input logic [2:0] tam);
    base_a = base; tam_a = tam; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic start_load_b(input logic [8:0] base, input logic [2:0] tam);
    base_b = base; tam_b = tam; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic run_a(input int maxc, input int glitch_cyc, output int done_cyc,
                       output int ndone, output int nrd, output int busy_first,
                       output int busy_last);
    done_cyc = -1; ndone = 0; nrd = 0; busy_first = -1; busy_last = -1;
    for (int k = 1; k <= maxc; k++) begin
      if (done_a) begin ndone++; if (done_cyc < 0) done_cyc = k; end
      if (mem_a.mem_rd) nrd++;
      if (busy_a) begin if (busy_first < 0) busy_first = k; busy_last = k; end
      start_a = (k == glitch_cyc);
      if (k == glitch_cyc) begin base_a = 9'h100; tam_a = 3'd3; end
      @(posedge clk); #1;
    end
    start_a = 1'b0;
  endtask

  task automatic run_b(input int maxc, output int done_cyc, output int ndone, output int nrd);
    done_cyc = -1; ndone = 0; nrd = 0;
    for (int k = 1; k <= maxc; k++) begin
      if (done_b) begin ndone++; if (done_cyc < 0) done_cyc = k; end
      if (mem_b.mem_rd) nrd++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b1; start_b = 1'b1;
    base_a = 9'h055; base_b = 9'h055; tam_a = 3'd2; tam_b = 3'd2;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mat_a !== '0) begin errors++; $display("FAIL reset_matriz_a: got %h, want 0", mat_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a: got %b, want 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done_a: got %b, want 0", done_a); end
    checks++; if (mem_a.mem_rd !== 1'b0) begin errors++; $display("FAIL reset_rd_a: got %b, want 0", mem_a.mem_rd); end
    checks++; if (mem_a.mem_addr !== 9'h0) begin errors++; $display("FAIL reset_addr_a: got %h, want 0", mem_a.mem_addr); end
    checks++; if (mat_b !== '0) begin errors++; $display("FAIL reset_matriz_b: got %h, want 0", mat_b); end
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b: got %b, want 0", busy_b); end
    rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_priority_a: busy got %b, want 0", busy_a); end
  endtask

  task automatic test_full_n5();
    int dc, nd, nr, bf, bl;
    logic [199:0] e;
    for (int i = 0; i < 512; i++) marr_a[i] = 8'(i);
    e = exp_mat(1'b0, 9'h010, 5);
    push_a(9'h010, 5);
    start_load_a(9'h010, 3'd5);
    run_a(40, -1, dc, nd, nr, bf, bl);
    checks++; if (dc != 27) begin errors++; $display("FAIL n5_done_cycle: got %0d, want 27", dc); end
    checks++; if (nd != 1) begin errors++; $display("FAIL n5_done_pulses: got %0d, want 1", nd); end
    checks++; if (nr != 25) begin errors++; $display("FAIL n5_reads: got %0d, want 25", nr); end
    checks++; if (bf != 1 || bl != 26) begin errors++; $display("FAIL n5_busy_window: got %0d..%0d, want 1..26", bf, bl); end
    checks++; if (mat_a !== e) begin errors++; $display("FAIL n5_matriz: got %h, want %h", mat_a, e); end
    checks++; if (mat_a[7:0] !== 8'h10 || mat_a[199:192] !== 8'h28) begin
      errors++; $display("FAIL n5_corners: got %h/%h, want 10/28", mat_a[7:0], mat_a[199:192]);
    end
    checks++; if (qa.size() != 0) begin errors++; $display("FAIL n5_pending: got %0d, want 0", qa.size()); end
  endtask

  task automatic test_n3();
    int dc, nd, nr, bf, bl;
    logic [199:0] e;
    for (int i = 0; i < 512; i++) marr_a[i] = 8'hA5;
    for (int k = 0; k < 9; k++) marr_a[9'h100 + k] = 8'(k + 1);
    e = exp_mat(1'b0, 9'h100, 3);
    push_a(9'h100, 3);
    start_load_a(9'h100, 3'd3);
    run_a(25, -1, dc, nd, nr, bf, bl);
    checks++; if (nr != 9) begin errors++; $display("FAIL n3_reads: got %0d, want 9", nr); end
    checks++; if (dc != 11 || nd != 1) begin errors++; $display("FAIL n3_done: got cyc %0d x%0d, want 11 x1", dc, nd); end
    checks++; if (mat_a !== e) begin errors++; $display("FAIL n3_matriz: got %h, want %h", mat_a, e); end
    checks++; if (mat_a[199:168] !== 32'h0 || mat_a[55:48] !== 8'h05) begin
      errors++; $display("FAIL n3_layout: got %h/%h, want 0/05", mat_a[199:168], mat_a[55:48]);
    end
  endtask

  task automatic test_wrap_lat3();
    int dc, nd, nr;
    logic [199:0] e;
    for (int i = 0; i < 512; i++) marr_b[i] = 8'(i) ^ 8'h5A;
    e = exp_mat(1'b1, 9'h1FE, 2);
    push_b(9'h1FE, 2);
    start_load_b(9'h1FE, 3'd2);
    run_b(20, dc, nd, nr);
    checks++; if (dc != 8 || nd != 1) begin errors++; $display("FAIL wrap_done: got cyc %0d x%0d, want 8 x1", dc, nd); end
    checks++; if (nr != 4) begin errors++; $display("FAIL wrap_reads: got %0d, want 4", nr); end
    checks++; if (mat_b !== e) begin errors++; $display("FAIL wrap_matriz: got %h, want %h", mat_b, e); end
    checks++; if (mat_b[7:0] !== 8'hA4 || mat_b[55:48] !== 8'h5B) begin
      errors++; $display("FAIL wrap_bytes: got %h/%h, want A4/5B", mat_b[7:0], mat_b[55:48]);
    end
  endtask

  task automatic test_start_ignored();
    int dc, nd, nr, bf, bl;
    logic [199:0] e;
    for (int i = 0; i < 512; i++) marr_a[i] = 8'(i) + 8'h33;
    e = exp_mat(1'b0, 9'h020, 5);
    push_a(9'h020, 5);
    start_load_a(9'h020, 3'd5);
    run_a(40, 5, dc, nd, nr, bf, bl);
    checks++; if (nr != 25) begin errors++; $display("FAIL ign_reads: got %0d, want 25", nr); end
    checks++; if (dc != 27 || nd != 1) begin errors++; $display("FAIL ign_done: got cyc %0d x%0d, want 27 x1", dc, nd); end
    checks++; if (mat_a !== e) begin errors++; $display("FAIL ign_matriz: got %h, want %h", mat_a, e); end
  endtask

  task automatic test_back_to_back();
    int dc, nd, nr, bf, bl;
    logic [199:0] e1, e2;
    for (int i = 0; i < 512; i++) marr_a[i] = 8'(i);
    e1 = exp_mat(1'b0, 9'h040, 2);
    e2 = exp_mat(1'b0, 9'h060, 2);
    push_a(9'h040, 2);
    start_load_a(9'h040, 3'd2);
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL b2b_done_first: got %b, want 1", done_a); end
    base_a = 9'h060; tam_a = 3'd2; start_a = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy_a !== 1'b0 || mem_a.mem_rd !== 1'b0) begin
      errors++; $display("FAIL b2b_start_on_done: busy/rd got %b/%b, want 0/0", busy_a, mem_a.mem_rd);
    end
    checks++; if (mat_a !== e1) begin errors++; $display("FAIL b2b_hold: got %h, want %h", mat_a, e1); end
    @(posedge clk); #1;
    start_a = 1'b0;
    push_a(9'h060, 2);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy got %b, want 1", busy_a); end
    checks++; if (mat_a !== '0) begin errors++; $display("FAIL b2b_clear: got %h, want 0", mat_a); end
    run_a(20, -1, dc, nd, nr, bf, bl);
    checks++; if (dc != 6 || nd != 1 || nr != 4) begin
      errors++; $display("FAIL b2b_second: got done %0d x%0d reads %0d, want 6 x1 reads 4", dc, nd, nr);
    end
    checks++; if (mat_a !== e2) begin errors++; $display("FAIL b2b_matriz: got %h, want %h", mat_a, e2); end
  endtask

  task automatic test_reset_mid();
    int nd;
    bit dirty;
    for (int i = 0; i < 512; i++) marr_a[i] = ~8'(i);
    push_a(9'h000, 1);
    for (int k = 1; k < 10; k++) qa.push_back(9'(k));
    start_load_a(9'h000, 3'd5);
    repeat (9) begin @(posedge clk); #1; end
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    checks++; if (mat_a !== '0) begin errors++; $display("FAIL mid_reset_matriz: got %h, want 0", mat_a); end
    checks++; if (busy_a !== 1'b0 || mem_a.mem_rd !== 1'b0) begin
      errors++; $display("FAIL mid_reset_ctrl: busy/rd got %b/%b, want 0/0", busy_a, mem_a.mem_rd);
    end
    nd = 0; dirty = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (done_a) nd++;
      if (mat_a !== '0) dirty = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (dirty) begin errors++; $display("FAIL mid_reset_late_data: matriz got %h, want 0", mat_a); end
    checks++; if (nd != 0) begin errors++; $display("FAIL mid_reset_done: got %0d pulses, want 0", nd); end
    checks++; if (qa.size() != 0) begin errors++; $display("FAIL mid_reset_reads: %0d of 10 missing", qa.size()); end
  endtask

  task automatic test_tamanho();
    int dc, nd, nr, bf, bl;
    logic [199:0] e;
    logic [2:0] tams [2];
    tams[0] = 3'd0; tams[1] = 3'd7;
    for (int i = 0; i < 512; i++) marr_a[i] = 8'(i * 3);
    e = exp_mat(1'b0, 9'h0C0, 5);
    for (int t = 0; t < 2; t++) begin
      push_a(9'h0C0, 5);
      start_load_a(9'h0C0, tams[t]);
      run_a(40, -1, dc, nd, nr, bf, bl);
      checks++; if (nr != 25 || dc != 27) begin
        errors++; $display("FAIL tam%0d_timing: got reads %0d done %0d, want 25/27", tams[t], nr, dc);
      end
      checks++; if (mat_a !== e) begin errors++; $display("FAIL tam%0d_matriz: got %h, want %h", tams[t], mat_a, e); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    base_a = '0; base_b = '0; tam_a = '0; tam_b = '0;
    test_reset();
    test_full_n5();
    test_n3();
    test_wrap_lat3();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_tamanho();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matriz_loader.md
Name: matriz_loader

Overview:
- Producer side of the matrix coprocessor datapath.
- Reads a square matrix of 8-bit elements, one byte per cycle, from a synchronous byte-wide memory starting at a base address.
- Packs the elements into the 200-bit 5x5 row-major vector consumed by the multiplier: element (linha, coluna) occupies bits 8*(coluna + 5*linha) +: 8.
- Positions outside the programmed dimension are zero-filled, so smaller matrices multiply correctly in the 5x5 engine.

Parameters:
- ADDR_W, 9, width of the memory byte address.
- RD_LAT, 1, memory read latency in cycles; legal range 1..3.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a load; sampled only in IDLE.
- base_addr  input  ADDR_W  address of element (0,0); sampled with start.
- tamanho  input  3  matrix dimension N; sampled with start; values 1..5 legal, 0 and 6..7 treated as 5.
- mem_rd  output  1  read strobe, one request per asserted cycle.
- mem_addr  output  ADDR_W  read address, valid while mem_rd=1.
- mem_rdata  input  8  read data, valid exactly RD_LAT cycles after the cycle its mem_rd was high.
- matriz  output  200  packed matrix.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset state (applies also mid-operation): state=IDLE; mem_rd=0; mem_addr=0; matriz=0; busy=0; done=0; read pipeline flushed. Data returning after reset is discarded.
- States:
  - IDLE -> ISSUE on start=1. In the same edge: latch N and base_addr; clear matriz to 0; clear the row/column counters.
  - ISSUE: mem_rd=1 every cycle. mem_addr = base + linha*N + coluna, produced by an incrementing counter with no multiplier. Column counter wraps at N-1 into the row counter. After request N*N-1 -> DRAIN.
  - DRAIN: mem_rd=0; wait until all in-flight reads are written -> DONE.
  - DONE: done=1 and busy=0 for exactly one cycle -> IDLE.
- Request pipeline:
  - Each request carries a valid bit and its destination index 5*linha + coluna through an RD_LAT-deep shift register.
  - When the valid bit emerges, the byte on mem_rdata is written to matriz[8*idx +: 8] at that edge.
- Timing: start accepted at edge 0. Requests occupy cycles 1..N*N. Last byte is captured at the end of cycle N*N+RD_LAT. done is high in cycle N*N+RD_LAT+1, e.g. N=5, RD_LAT=1 gives done in cycle 27.
- busy: high from cycle 1 through cycle N*N+RD_LAT inclusive.
- matriz contents:
  - Positions with linha>=N or coluna>=N stay 0.
  - matriz holds its final value after done until the next accepted start or reset.
  - While busy=1, matriz is partial and must not be used.
- start handling:
  - Ignored while busy or in DONE; no queuing.
  - start asserted in the same cycle as done is ignored. A start in the cycle after done is accepted.
- Address arithmetic: ADDR_W-bit modulo; a load crossing the top of memory wraps to 0 without error.
- reset has priority over start in the same cycle.

Test Plan:
- N=5, RD_LAT=1, base=0x010, memory[a]=a[7:0] -> addresses 0x010..0x028 in order, one per cycle. matriz element (r,c) = 0x10+5r+c. done is a single pulse in cycle 27.
- N=3, base=0x100, memory[0x100+k]=k+1 -> element (r,c)=3r+c+1 for r,c<3; all other 16 bytes 0. Exactly 9 mem_rd cycles.
- RD_LAT=3, N=2, base=0x1FE (ADDR_W=9) -> addresses 0x1FE, 0x1FF, 0x000, 0x001. Data lands correctly. done is in cycle 8.
- start pulsed again during ISSUE with different base -> ignored; result and request count identical to the single-start run. A start in the cycle after done begins a new load and clears matriz.
- reset asserted in cycle 10 of an N=5 load -> next cycle matriz=0, busy=0, mem_rd=0. Late read data does not modify matriz. No done pulse.
- tamanho=0 and tamanho=7 -> behaves exactly as N=5: 25 reads, full matrix.
